wavegen_poly: RTL and testbench

//  Polyphonic, parametrised wavetable voice engine: NV voices, each with its own NCO, two

---
 rtl/wavegen_poly.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wavegen_poly.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavegen_poly.sv
// Polyphonic wavetable voice engine: per-voice NCO, flash-sequenced A/B table reads,
// linear interpolation, A/B blend and an even-left / odd-right saturating mix.
module wavegen_poly #(
  parameter int NV  = 4,
  parameter int FSZ = 32,
  parameter int PSZ = 11,
  parameter int WSL = 10,
  parameter int WSZ = 16,
  parameter int OSZ = 24,
  parameter int ASZ = 24,
  parameter int HR  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [NV*FSZ-1:0] freq,
  input  logic [NV*WSL-1:0] wave_a,
  input  logic [NV*WSL-1:0] wave_b,
  input  logic [NV*16-1:0]  blend,
  output logic              rd_req,
  output logic [ASZ-1:0]    rd_addr,
  input  logic              rd_ack,
  input  logic [WSZ-1:0]    rd_data,
  output logic [OSZ-1:0]    l_data,
  output logic [OSZ-1:0]    r_data,
  output logic              busy,
  output logic              overrun
);

  localparam int VW  = $clog2(NV);
  localparam int ACW = OSZ + 5;
  localparam int SH  = OSZ - WSZ - HR;
  localparam logic [VW-1:0] LAST_V = VW'(NV - 1);
  localparam logic signed [ACW-1:0] SAT_MAX = {{(ACW-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [ACW-1:0] SAT_MIN = {{(ACW-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_CALC = 2'd2} state_t;

  // Weighted pair with rounding: (a*(65536-w) + b*w + 2^15) >>> 16, wrapped to WSZ bits.
  function automatic logic signed [WSZ-1:0] lerp(input logic signed [WSZ-1:0] a,
                                                 input logic signed [WSZ-1:0] b,
                                                 input logic [15:0] w);
    logic signed [WSZ+18:0] ae, be, wa, wb, s;
    ae = {{19{a[WSZ-1]}}, a};
    be = {{19{b[WSZ-1]}}, b};
    wb = {{(WSZ+3){1'b0}}, w};
    wa = {{(WSZ+2){1'b0}}, 17'h10000} - wb;
    s  = ae * wa + be * wb + {{(WSZ+3){1'b0}}, 16'h8000};
    return WSZ'(s >>> 16);
  endfunction

  function automatic logic signed [OSZ-1:0] sat_out(input logic signed [ACW-1:0] a);
    if (a > SAT_MAX) begin
      return SAT_MAX[OSZ-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[OSZ-1:0];
    end else begin
      return OSZ'(a);
    end
  endfunction

  logic [FSZ-1:0] freq_s  [NV];
  logic [WSL-1:0] wa_s    [NV];
  logic [WSL-1:0] wb_s    [NV];
  logic [15:0]    blend_s [NV];

  for (genvar g = 0; g < NV; g++) begin : g_unpack
    assign freq_s[g]  = freq[g*FSZ +: FSZ];
    assign wa_s[g]    = wave_a[g*WSL +: WSL];
    assign wb_s[g]    = wave_b[g*WSL +: WSL];
    assign blend_s[g] = blend[g*16 +: 16];
  end

  state_t                 state_q, state_d;
  logic [VW-1:0]          voice_q, voice_d;
  logic [1:0]             read_q, read_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   stale_q, stale_d;
  logic                   rd_req_q, rd_req_d;
  logic [ASZ-1:0]         rd_addr_q, rd_addr_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic signed [OSZ-1:0]  l_data_q, l_data_d, r_data_q, r_data_d;
  logic signed [OSZ-1:0]  done_l_q, done_l_d, done_r_q, done_r_d;
  logic signed [ACW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [WSZ-1:0]  x_q [4];
  logic signed [WSZ-1:0]  x_d [4];
  logic signed [WSZ-1:0]  ya_q, ya_d, yb_q, yb_d, vo_q, vo_d;
  logic [FSZ-1:0]         phase_q [NV];
  logic [FSZ-1:0]         phase_d [NV];

  logic [PSZ-1:0]         cur_idx_s, index_s;
  logic [15:0]            cur_frac_s;
  logic [WSL-1:0]         sel_s;
  logic [ASZ-1:0]         req_addr_s;
  logic signed [ACW-1:0]  scaled_s;

  // Read order per voice: A idx, A idx+1, B idx, B idx+1 (index wraps inside the table).
  assign cur_idx_s  = phase_q[voice_q][FSZ-1 -: PSZ];
  assign cur_frac_s = phase_q[voice_q][FSZ-PSZ-1 -: 16];
  assign sel_s      = read_q[1] ? wb_s[voice_q] : wa_s[voice_q];
  assign index_s    = read_q[0] ? cur_idx_s + {{(PSZ-1){1'b0}}, 1'b1} : cur_idx_s;
  assign req_addr_s = ASZ'({sel_s, index_s, 1'b0});
  assign scaled_s   = {{(ACW-WSZ){vo_q[WSZ-1]}}, vo_q} <<< SH;

  // Frame sequencer: issue reads, run the 4-stage voice pipeline, handle ena restarts.
  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    read_d    = read_q;
    cnt_d     = cnt_q;
    stale_d   = stale_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    overrun_d = 1'b0;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    done_l_d  = done_l_q;
    done_r_d  = done_r_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    x_d       = x_q;
    ya_d      = ya_q;
    yb_d      = yb_q;
    vo_d      = vo_q;
    phase_d   = phase_q;

    case (state_q)
      S_IDLE: busy_d = 1'b0;
      S_REQ: begin
        if (!rd_req_q) begin
          rd_req_d  = 1'b1;
          rd_addr_d = req_addr_s;
        end else if (rd_ack) begin
          rd_req_d = 1'b0;
          if (stale_q) begin
            stale_d = 1'b0;
          end else begin
            x_d[read_q] = $signed(rd_data);
            if (read_q == 2'd3) begin
              read_d  = 2'd0;
              cnt_d   = 2'd0;
              state_d = S_CALC;
            end else begin
              read_d = read_q + 2'd1;
            end
          end
        end else begin
          rd_req_d = 1'b1;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin
            ya_d = lerp(x_q[0], x_q[1], cur_frac_s);
            yb_d = lerp(x_q[2], x_q[3], cur_frac_s);
          end
          2'd1: vo_d = lerp(ya_q, yb_q, blend_s[voice_q]);
          2'd2: begin
            if (voice_q[0]) begin
              acc_r_d = acc_r_q + scaled_s;
            end else begin
              acc_l_d = acc_l_q + scaled_s;
            end
          end
          2'd3: begin
            if (voice_q == LAST_V) begin
              state_d  = S_IDLE;
              busy_d   = 1'b0;
              done_l_d = sat_out(acc_l_q);
              done_r_d = sat_out(acc_r_q);
            end else begin
              voice_d = voice_q + {{(VW-1){1'b0}}, 1'b1};
              state_d = S_REQ;
            end
          end
          default: cnt_d = 2'd0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // A pending request keeps its address; its ack is swallowed via stale.
    if (ena) begin
      for (int v = 0; v < NV; v++) begin
        phase_d[v] = phase_q[v] + freq_s[v];
      end
      overrun_d = busy_q;
      l_data_d  = done_l_q;
      r_data_d  = done_r_q;
      state_d   = S_REQ;
      voice_d   = {VW{1'b0}};
      read_d    = 2'd0;
      cnt_d     = 2'd0;
      busy_d    = 1'b1;
      acc_l_d   = {ACW{1'b0}};
      acc_r_d   = {ACW{1'b0}};
      rd_req_d  = rd_req_q & ~rd_ack;
      stale_d   = rd_req_q & ~rd_ack;
    end else begin
      overrun_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      voice_q   <= {VW{1'b0}};
      read_q    <= 2'd0;
      cnt_q     <= 2'd0;
      stale_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= {ASZ{1'b0}};
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      l_data_q  <= {OSZ{1'b0}};
      r_data_q  <= {OSZ{1'b0}};
      done_l_q  <= {OSZ{1'b0}};
      done_r_q  <= {OSZ{1'b0}};
      acc_l_q   <= {ACW{1'b0}};
      acc_r_q   <= {ACW{1'b0}};
      ya_q      <= {WSZ{1'b0}};
      yb_q      <= {WSZ{1'b0}};
      vo_q      <= {WSZ{1'b0}};
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= {WSZ{1'b0}};
      end
      for (int v = 0; v < NV; v++) begin
        phase_q[v] <= {FSZ{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      read_q    <= read_d;
      cnt_q     <= cnt_d;
      stale_q   <= stale_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
      done_l_q  <= done_l_d;
      done_r_q  <= done_r_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      ya_q      <= ya_d;
      yb_q      <= yb_d;
      vo_q      <= vo_d;
      x_q       <= x_d;
      phase_q   <= phase_d;
    end
  end

  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign l_data  = l_data_q;
  assign r_data  = r_data_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_wavegen_poly.sv
// Directed bench for wavegen_poly: flash responder model plus hand-computed frame mixes.
module tb_wavegen_poly;
  localparam int NV = 4, FSZ = 32, PSZ = 11, WSL = 10, WSZ = 16, OSZ = 24, ASZ = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ena = 1'b0;
  logic [NV*FSZ-1:0] freq;
  logic [NV*WSL-1:0] wave_a, wave_b;
  logic [NV*16-1:0]  blend;
  logic              rd_req, rd_ack, busy, overrun;
  logic [ASZ-1:0]    rd_addr;
  logic [WSZ-1:0]    rd_data;
  logic [OSZ-1:0]    l_data, r_data;
  logic              rd_req0, rd_ack0, busy0, overrun0;
  logic [ASZ-1:0]    rd_addr0;
  logic [WSZ-1:0]    rd_data0;
  logic [OSZ-1:0]    l_data0, r_data0;

  int n_cmp = 0;
  int n_bad = 0;
  int dly = 1;
  int cnt = 0;
  int viol = 0;
  int ov_count = 0;
  logic [15:0] default_val = 16'h0000;
  logic [ASZ-1:0] req_addr;
  logic [15:0] mem [int];
  logic [ASZ-1:0] addr_log [$];

  wavegen_poly dut (
    .clk(clk), .reset(reset), .ena(ena), .freq(freq), .wave_a(wave_a), .wave_b(wave_b),
    .blend(blend), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .l_data(l_data), .r_data(r_data), .busy(busy), .overrun(overrun)
  );

  wavegen_poly #(.HR(0)) dut0 (
    .clk(clk), .reset(reset), .ena(ena), .freq(freq), .wave_a(wave_a), .wave_b(wave_b),
    .blend(blend), .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_ack(rd_ack0), .rd_data(rd_data0),
    .l_data(l_data0), .r_data(r_data0), .busy(busy0), .overrun(overrun0)
  );

  always #5 clk = ~clk;

  function automatic int akey(input logic [WSL-1:0] sel, input logic [PSZ-1:0] idx);
    return (int'(sel) << (PSZ + 1)) | (int'(idx) << 1);
  endfunction

  function automatic logic [15:0] rd_mem(input logic [ASZ-1:0] a);
    int k;
    k = int'(a);
    if (mem.exists(k)) return mem[k];
    else return default_val;
  endfunction

  // Main flash model: ack after dly cycles of rd_req, checks address stability.
  always @(negedge clk) begin
    if (reset) begin
      rd_ack = 1'b0;
      cnt = 0;
    end else if (rd_ack) begin
      rd_ack = 1'b0;
      cnt = 0;
    end else if (rd_req) begin
      if (cnt == 0) req_addr = rd_addr;
      else if (rd_addr != req_addr) viol++;
      cnt++;
      if (cnt >= dly) begin
        rd_ack = 1'b1;
        rd_data = rd_mem(rd_addr);
        addr_log.push_back(rd_addr);
      end
    end else begin
      cnt = 0;
    end
  end

  // Headroom-free instance: every sample full-scale positive, 1-cycle ack.
  always @(negedge clk) begin
    if (reset) rd_ack0 = 1'b0;
    else if (rd_ack0) rd_ack0 = 1'b0;
    else if (rd_req0) begin
      rd_ack0 = 1'b1;
      rd_data0 = 16'h7FFF;
    end else rd_ack0 = 1'b0;
  end

  always @(negedge clk) begin
    if (overrun) ov_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_voice(input int v, input logic [31:0] f, input logic [WSL-1:0] a,
                           input logic [WSL-1:0] b, input logic [15:0] bl);
    freq[v*FSZ +: FSZ] = f;
    wave_a[v*WSL +: WSL] = a;
    wave_b[v*WSL +: WSL] = b;
    blend[v*16 +: 16] = bl;
  endtask

  task automatic pulse_ena();
    @(negedge clk) ena = 1'b1;
    @(negedge clk) ena = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || busy0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, busy, busy0}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    freq = {(NV*FSZ){1'b0}};
    wave_a = {(NV*WSL){1'b0}};
    wave_b = {(NV*WSL){1'b0}};
    blend = {(NV*16){1'b0}};
    repeat (3) @(negedge clk);
    check("rst_l", l_data, 32'h0);
    check("rst_r", r_data, 32'h0);
    check("rst_req", rd_req, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_ovr", overrun, 32'h0);
    reset = 1'b0;

    // Constant 0x1000 everywhere: two voices per side, each 0x1000 << 6.
    for (int v = 0; v < NV; v++) set_voice(v, 32'h0, 10'(v), 10'(v + 8), 16'h0);
    default_val = 16'h1000;
    pulse_ena();
    wait_idle("t1_idle");
    pulse_ena();
    check("t1_l", l_data, 32'h080000);
    check("t1_r", r_data, 32'h080000);
    wait_idle("t1_idle2");

    // Half-way interpolation between 0 and 0x2000 on voice 0.
    apply_reset();
    mem.delete();
    default_val = 16'h0000;
    set_voice(0, 32'h0010_0000, 10'h001, 10'h002, 16'h0);
    for (int v = 1; v < NV; v++) set_voice(v, 32'h0, 10'(v + 256), 10'(v + 512), 16'h0);
    mem[akey(10'h001, 11'h000)] = 16'h0000;
    mem[akey(10'h001, 11'h001)] = 16'h2000;
    pulse_ena();
    wait_idle("t2_idle");
    pulse_ena();
    check("t2_l", l_data, 32'h040000);
    check("t2_r", r_data, 32'h0);
    wait_idle("t2_idle2");

    // Blend: A=+0x4000, B=-0x4000; v0 half, v1 none, v2 quarter.
    apply_reset();
    mem.delete();
    default_val = 16'h0000;
    set_voice(0, 32'h0, 10'h003, 10'h004, 16'h8000);
    set_voice(1, 32'h0, 10'h003, 10'h004, 16'h0000);
    set_voice(2, 32'h0, 10'h003, 10'h004, 16'h4000);
    set_voice(3, 32'h0, 10'h009, 10'h009, 16'h0000);
    mem[akey(10'h003, 11'h000)] = 16'h4000;
    mem[akey(10'h003, 11'h001)] = 16'h4000;
    mem[akey(10'h004, 11'h000)] = 16'hC000;
    mem[akey(10'h004, 11'h001)] = 16'hC000;
    pulse_ena();
    wait_idle("t3_idle");
    pulse_ena();
    check("t3_l", l_data, 32'h080000);
    check("t3_r", r_data, 32'h100000);
    wait_idle("t3_idle2");
    set_voice(0, 32'h0, 10'h003, 10'h004, 16'h0000);
    pulse_ena();
    check("t3_hold", l_data, 32'h080000);
    wait_idle("t3_idle3");
    pulse_ena();
    check("t3_l0", l_data, 32'h180000);
    check("t3_r0", r_data, 32'h100000);
    wait_idle("t3_idle4");

    // Top-of-table index wraps to 0 in the same table; HR=0 instance saturates.
    apply_reset();
    mem.delete();
    default_val = 16'h0000;
    set_voice(0, 32'hFFE0_0000, 10'h005, 10'h006, 16'h0);
    for (int v = 1; v < NV; v++) set_voice(v, 32'h0, 10'(v), 10'(v), 16'h0);
    addr_log.delete();
    pulse_ena();
    wait_idle("t4_idle");
    check("t4_a0", (addr_log.size() > 0) ? addr_log[0] : 24'hFFFFFF, 32'h005FFE);
    check("t4_a1", (addr_log.size() > 1) ? addr_log[1] : 24'hFFFFFF, 32'h005000);
    check("t4_b0", (addr_log.size() > 2) ? addr_log[2] : 24'hFFFFFF, 32'h006FFE);
    check("t4_b1", (addr_log.size() > 3) ? addr_log[3] : 24'hFFFFFF, 32'h006000);
    pulse_ena();
    check("t4_sat_l", l_data0, 32'h7FFFFF);
    check("t4_sat_r", r_data0, 32'h7FFFFF);
    wait_idle("t4_idle2");

    // Slow flash, ena every 40 cycles: overruns, outputs hold the last full frame.
    apply_reset();
    mem.delete();
    default_val = 16'h1000;
    for (int v = 0; v < NV; v++) set_voice(v, 32'h0, 10'(v), 10'(v + 8), 16'h0);
    pulse_ena();
    wait_idle("t5_idle");
    dly = 8;
    ov_count = 0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_ena();
      check("t5_hold", l_data, 32'h080000);
      if (i == 4) default_val = 16'h2000;
      repeat (38) @(negedge clk);
    end
    check("t5_ovr_cnt", ov_count, 32'd4);
    check("t5_addr_stable", viol, 32'd0);
    wait_idle("t5_idle2");
    pulse_ena();
    check("t5_restart_l", l_data, 32'h100000);
    check("t5_restart_r", r_data, 32'h100000);
    wait_idle("t5_idle3");

    // Reset in the middle of a pending read.
    apply_reset();
    mem.delete();
    default_val = 16'h1000;
    dly = 3;
    set_voice(0, 32'h0, 10'h00A, 10'h00B, 16'h0);
    for (int v = 1; v < NV; v++) set_voice(v, 32'h0, 10'(v), 10'(v + 8), 16'h0);
    pulse_ena();
    wait_idle("t6_idle");
    pulse_ena();
    check("t6_pre_l", l_data, 32'h080000);
    for (int n = 0; n < 100 && !rd_req; n++) @(negedge clk);
    check("t6_req_seen", rd_req, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req", rd_req, 32'h0);
    check("t6_busy", busy, 32'h0);
    check("t6_l", l_data, 32'h0);
    check("t6_r", r_data, 32'h0);
    reset = 1'b0;
    dly = 1;
    @(negedge clk);
    addr_log.delete();
    pulse_ena();
    check("t6_first_l", l_data, 32'h0);
    wait_idle("t6_idle2");
    check("t6_first_addr", (addr_log.size() > 0) ? addr_log[0] : 24'hFFFFFF, 32'h00A000);
    pulse_ena();
    check("t6_post_l", l_data, 32'h080000);
    check("t6_post_r", r_data, 32'h080000);
    wait_idle("t6_idle3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
